// File: rtl/tdm_tx.sv
// tdm_tx: multi-channel serial audio transmitter (stereo I2S when NUM_CH=2,
// TDM otherwise). SCK and WS are derived from clk; one frame of samples is
// accepted through a valid/ready handshake into a holding buffer and copied
// into the active frame at every frame start.
//
// Optional feature macro: TDM_TX_I2S_DELAY_EN
//   defined   : sd lags ws by one SCK cycle (Philips I2S data delay)
//   undefined : left-justified, sd carries the bit of the current position
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   s_data       one frame of samples, channel c at [c*DAT_WDTH +: DAT_WDTH]
//   s_valid      s_data valid
//   s_ready      holding buffer empty
//   sck          serial bit clock
//   ws           word select (0 for first half of the frame, 1 for second)
//   sd           serial data, MSB first
//   frame_start  one-clk pulse marking bit 0 of each frame
//   underflow    one-clk pulse when a frame starts with no data held
module tdm_tx #(
   parameter int unsigned DAT_WDTH  = 24,
   parameter int unsigned SLOT_WDTH = 32,
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned CLK_DIV   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH*DAT_WDTH-1:0] s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic                       sck,
   output logic                       ws,
   output logic                       sd,
   output logic                       frame_start,
   output logic                       underflow
);

   localparam int unsigned FRM_W  = NUM_CH * DAT_WDTH;
   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W  = (SLOT_WDTH > 1) ? $clog2(SLOT_WDTH) : 1;
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned DIDX_W = (DAT_WDTH > 1) ? $clog2(DAT_WDTH) : 1;

   logic [DIV_W-1:0]  r_div_cnt;
   logic              r_sck;
   logic [BIT_W-1:0]  r_bit;
   logic [CH_W-1:0]   r_slot;
   logic [FRM_W-1:0]  r_hold;
   logic              r_hold_full;
   logic              r_s_ready;
   logic [FRM_W-1:0]  r_active;
   logic              r_ws;
   logic              r_sd;
   logic              r_frame_start;
   logic              r_underflow;
`ifdef TDM_TX_I2S_DELAY_EN
   logic              r_cur_bit;
`endif

   logic              w_tick;
   logic              w_bit_wrap;
   logic              w_frame_wrap;
   logic              w_frame_start;
   logic              w_xfer;
   logic              w_hold_full_nxt;
   logic [BIT_W-1:0]  w_bit_nxt;
   logic [CH_W-1:0]   w_slot_nxt;
   logic [FRM_W-1:0]  w_src;
   logic [DAT_WDTH-1:0] w_word;
   logic              w_map_bit;

   // Tick = the clk edge on which sck falls
   always_comb begin
      w_tick        = (r_div_cnt == '0) && r_sck;
      w_bit_wrap    = (r_bit == BIT_W'(SLOT_WDTH - 1));
      w_frame_wrap  = w_bit_wrap && (r_slot == CH_W'(NUM_CH - 1));
      w_frame_start = w_tick && w_frame_wrap;
      w_xfer        = s_valid && !r_hold_full;
   end

   // Next bit position (slot, bit-in-slot)
   always_comb begin
      w_bit_nxt  = w_bit_wrap ? '0 : r_bit + BIT_W'(1);
      w_slot_nxt = r_slot;
      if (w_bit_wrap) begin
         w_slot_nxt = (r_slot == CH_W'(NUM_CH - 1)) ? '0 : r_slot + CH_W'(1);
      end
   end

   // Holding buffer occupancy: frame start drains it, a transfer fills it
   always_comb begin
      w_hold_full_nxt = r_hold_full;
      if (w_frame_start && r_hold_full) begin
         w_hold_full_nxt = 1'b0;
      end else if (w_xfer) begin
         w_hold_full_nxt = 1'b1;
      end
   end

   // Bit mapped to the next position; at a frame start the new frame is
   // read straight from the holding buffer (or zeros on underflow)
   always_comb begin
      w_src = r_active;
      if (w_frame_start) begin
         w_src = r_hold_full ? r_hold : '0;
      end
      w_word = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (w_slot_nxt == CH_W'(c)) begin
            w_word = w_src[c*DAT_WDTH +: DAT_WDTH];
         end
      end
      w_map_bit = 1'b0;
      if (int'(w_bit_nxt) < int'(DAT_WDTH)) begin
         w_map_bit = w_word[DIDX_W'(DAT_WDTH - 1) - DIDX_W'(w_bit_nxt)];
      end
   end

   // SCK divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= DIV_W'(CLK_DIV - 1);
         r_sck     <= 1'b0;
      end else if (r_div_cnt == '0) begin
         r_div_cnt <= DIV_W'(CLK_DIV - 1);
         r_sck     <= !r_sck;
      end else begin
         r_div_cnt <= r_div_cnt - DIV_W'(1);
      end
   end

   // Handshake and holding buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_s_ready   <= 1'b1;
      end else begin
         if (w_xfer) begin
            r_hold <= s_data;
         end
         r_hold_full <= w_hold_full_nxt;
         r_s_ready   <= !w_hold_full_nxt;
      end
   end

   // Frame position, active frame and serial outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit         <= BIT_W'(SLOT_WDTH - 1);
         r_slot        <= CH_W'(NUM_CH - 1);
         r_active      <= '0;
         r_ws          <= 1'b0;
         r_sd          <= 1'b0;
         r_frame_start <= 1'b0;
         r_underflow   <= 1'b0;
`ifdef TDM_TX_I2S_DELAY_EN
         r_cur_bit     <= 1'b0;
`endif
      end else begin
         r_frame_start <= w_frame_start;
         r_underflow   <= w_frame_start && !r_hold_full;
         if (w_tick) begin
            r_bit  <= w_bit_nxt;
            r_slot <= w_slot_nxt;
            r_ws   <= (w_slot_nxt >= CH_W'(NUM_CH / 2));
`ifdef TDM_TX_I2S_DELAY_EN
            // Output the previous position's bit, remember the current one
            r_sd      <= r_cur_bit;
            r_cur_bit <= w_map_bit;
`else
            r_sd      <= w_map_bit;
`endif
            if (w_frame_start) begin
               r_active <= w_src;
            end
         end
      end
   end

   assign s_ready     = r_s_ready;
   assign sck         = r_sck;
   assign ws          = r_ws;
   assign sd          = r_sd;
   assign frame_start = r_frame_start;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_tdm_tx.sv
// tb_tdm_tx: directed bench for tdm_tx. A stereo instance (defaults) and a
// 4-channel TDM instance; frames are captured one bit per SCK fall and
// compared against hand-built serial images.
module tb_tdm_tx;

`ifdef TDM_TX_I2S_DELAY_EN
   localparam bit DLY = 1'b1;
`else
   localparam bit DLY = 1'b0;
`endif
   localparam logic [63:0] WS_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

   logic        clk;
   logic        rst_n, rst2_n;
   logic [47:0] s_data1;
   logic [63:0] s_data2;
   logic        s_valid1, s_valid2;
   logic        s_ready1, sck1, ws1, sd1, fs1, uf1;
   logic        s_ready2, sck2, ws2, sd2, fs2, uf2;

   tdm_tx #(.DAT_WDTH(24), .SLOT_WDTH(32), .NUM_CH(2), .CLK_DIV(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data1), .s_valid(s_valid1),
      .s_ready(s_ready1), .sck(sck1), .ws(ws1), .sd(sd1),
      .frame_start(fs1), .underflow(uf1));

   tdm_tx #(.DAT_WDTH(16), .SLOT_WDTH(16), .NUM_CH(4), .CLK_DIV(2)) u_dut_tdm (
      .clk(clk), .rst_n(rst2_n), .s_data(s_data2), .s_valid(s_valid2),
      .s_ready(s_ready2), .sck(sck2), .ws(ws2), .sd(sd2),
      .frame_start(fs2), .underflow(uf2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed DUT selected by sel
   logic sel;
   logic m_sck, m_ws, m_sd, m_fs, m_uf, m_ready;
   assign m_sck   = sel ? sck2 : sck1;
   assign m_ws    = sel ? ws2 : ws1;
   assign m_sd    = sel ? sd2 : sd1;
   assign m_fs    = sel ? fs2 : fs1;
   assign m_uf    = sel ? uf2 : uf1;
   assign m_ready = sel ? s_ready2 : s_ready1;

   int   checks, errors;
   int   cyc_since_tick, last_cyc, glitch_cnt, pulse_cnt, transfers;
   bit   ticked, bb_mode;
   logic last_sd, last_ws, prev_last;

   typedef struct {
      bit          push;
      logic [63:0] pdata;
      logic [63:0] exp_data;
      bit          exp_uf;
      bit          exp_ready;
   } vec_t;
   vec_t vecs[6];

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int k);
      return {16'h0000, 24'h5A5A00 + 24'(k), 24'hA5A500 + 24'(k)};
   endfunction

   // Serial image of one frame, bit 63 = position 0
   function automatic logic [63:0] ser(input logic [63:0] d);
      if (sel) return {d[15:0], d[31:16], d[47:32], d[63:48]};
      return {d[23:0], 8'h00, d[47:24], 8'h00};
   endfunction

   task automatic resync();
      ticked         = 1'b0;
      cyc_since_tick = 0;
      last_sd        = m_sd;
      last_ws        = m_ws;
   endtask

   // One clk cycle; sampled 1 time unit after the edge
   task automatic clk_step();
      logic ps, pr;
      logic [63:0] nd;
      ps = m_sck;
      pr = m_ready;
      @(posedge clk);
      #1;
      cyc_since_tick++;
      if (ps && !m_sck) begin
         ticked         = 1'b1;
         last_cyc       = cyc_since_tick;
         cyc_since_tick = 0;
         last_sd        = m_sd;
         last_ws        = m_ws;
      end else begin
         if (m_sd !== last_sd || m_ws !== last_ws) glitch_cnt++;
         if (m_fs || m_uf) pulse_cnt++;
      end
      if (bb_mode && s_valid1 && pr) begin
         transfers++;
         nd      = pat(transfers);
         s_data1 = nd[47:0];
      end
   endtask

   task automatic wait_tick(output int cyc, output bit ok);
      int n;
      n = 0;
      while (!ticked && n < 64) begin
         clk_step();
         n++;
      end
      ok     = ticked;
      ticked = 1'b0;
      cyc    = last_cyc;
   endtask

   task automatic push(input logic [63:0] d);
      if (sel) begin
         s_data2  = d;
         s_valid2 = 1'b1;
      end else begin
         s_data1  = d[47:0];
         s_valid1 = 1'b1;
      end
      clk_step();
      s_valid1 = 1'b0;
      s_valid2 = 1'b0;
   endtask

   // Capture a whole frame starting at the next tick and check it
   task automatic frame(input string tag, input bit do_push, input logic [63:0] pd,
                        input logic [63:0] exp_d, input bit exp_uf, input bit exp_ready);
      logic [63:0] sdv, wsv, s, exp_s;
      logic fs0, uf0;
      bit   ok;
      int   cyc, bad_t, div;
      sdv = '0; wsv = '0; fs0 = 1'b0; uf0 = 1'b0; bad_t = 0;
      div = sel ? 4 : 8;
      for (int p = 0; p < 64; p++) begin
         wait_tick(cyc, ok);
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no tick at position %0d", tag, p);
            return;
         end
         if (cyc != div) bad_t++;
         sdv = {sdv[62:0], m_sd};
         wsv = {wsv[62:0], m_ws};
         if (p == 0) begin
            fs0 = m_fs;
            uf0 = m_uf;
            if (do_push) push(pd);
         end
      end
      s     = ser(exp_d);
      exp_s = DLY ? {prev_last, s[63:1]} : s;
      prev_last = s[0];
      chk64({tag, "_sd"}, sdv, exp_s);
      chk64({tag, "_ws"}, wsv, WS_EXP);
      chk1({tag, "_frame_start"}, fs0, 1'b1);
      chk1({tag, "_underflow"}, uf0, exp_uf);
      chk1({tag, "_ready_end"}, m_ready, exp_ready);
      chkn({tag, "_tick_spacing"}, bad_t, 0);
   endtask

   localparam logic [63:0] FA = {16'h0, 24'h123456, 24'hABCDEF};
   localparam logic [63:0] FB = {16'h0, 24'h654321, 24'h0F1E2D};
   localparam logic [63:0] FC = {16'h0, 24'h800001, 24'h7FFFFE};
   localparam logic [63:0] FE = {16'h0, 24'hFFFFFF, 24'h3C3C3C};
   localparam logic [63:0] FF = {16'h0, 24'h111111, 24'h222222};
   localparam logic [63:0] FG = {16'h0, 24'h0A0B0C, 24'hF0E0D0};
   localparam logic [63:0] FT = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

   initial begin
      int  cyc;
      bit  ok;
      vecs[0] = '{1'b1, FB, FA, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 64'h0, FB, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 64'h0, 64'h0, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 64'h0, 64'h0, 1'b1, 1'b1};
      vecs[4] = '{1'b1, FC, 64'h0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, FE, FC, 1'b0, 1'b0};

      checks = 0; errors = 0; glitch_cnt = 0; pulse_cnt = 0; transfers = 0;
      sel = 1'b0; bb_mode = 1'b0; prev_last = 1'b0;
      s_valid1 = 1'b0; s_valid2 = 1'b0; s_data1 = '0; s_data2 = '0;
      rst_n = 1'b1; rst2_n = 1'b1;
      #1;
      rst_n = 1'b0; rst2_n = 1'b0;
      #10;
      chk1("rst_sck", sck1, 1'b0);
      chk1("rst_ws", ws1, 1'b0);
      chk1("rst_sd", sd1, 1'b0);
      chk1("rst_frame_start", fs1, 1'b0);
      chk1("rst_underflow", uf1, 1'b0);
      chk1("rst_s_ready", s_ready1, 1'b1);
      chk1("rst_tdm_sck", sck2, 1'b0);
      chk1("rst_tdm_ready", s_ready2, 1'b1);

      // Stereo: frame A offered before the first tick
      s_data1 = FA[47:0];
      s_valid1 = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      resync();
      clk_step();
      s_valid1 = 1'b0;
      chk1("ready_after_accept", s_ready1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         frame($sformatf("vec%0d", i), vecs[i].push, vecs[i].pdata,
               vecs[i].exp_data, vecs[i].exp_uf, vecs[i].exp_ready);
      end

      // Reset in slot 1 with the holding buffer full
      for (int p = 0; p <= 40; p++) begin
         wait_tick(cyc, ok);
         if (!ok) begin
            $display("FAIL midrst_timeout: no tick at position %0d", p);
            $fatal(1);
         end
         if (p == 0) begin
            chk1("midrst_fs", m_fs, 1'b1);
            chk1("midrst_uf", m_uf, 1'b0);
            push(FF);
         end
      end
      chk1("midrst_pre_ws", ws1, 1'b1);
      chk1("midrst_pre_sd", sd1, 1'b1);
      chk1("midrst_pre_ready", s_ready1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("midrst_sck", sck1, 1'b0);
      chk1("midrst_ws", ws1, 1'b0);
      chk1("midrst_sd", sd1, 1'b0);
      chk1("midrst_fs0", fs1, 1'b0);
      chk1("midrst_uf0", uf1, 1'b0);
      chk1("midrst_ready", s_ready1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      resync();
      prev_last = 1'b0;
      frame("postrst0", 1'b1, FG, 64'h0, 1'b1, 1'b0);
      frame("postrst1", 1'b0, 64'h0, FG, 1'b0, 1'b1);

      // Back-to-back: s_valid held high, data steps on every transfer
      #2;
      rst_n = 1'b0;
      begin
         logic [63:0] p0;
         p0 = pat(0);
         s_data1 = p0[47:0];
      end
      s_valid1 = 1'b1;
      bb_mode = 1'b1;
      transfers = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      resync();
      prev_last = 1'b0;
      for (int k = 0; k < 5; k++) begin
         frame($sformatf("bb%0d", k), 1'b0, 64'h0, pat(k), 1'b0, 1'b0);
      end
      chkn("bb_transfers", transfers, 6);
      bb_mode = 1'b0;
      s_valid1 = 1'b0;

      // TDM: 4 channels of 16 bits
      sel = 1'b1;
      s_data2 = FT;
      s_valid2 = 1'b1;
      @(posedge clk);
      #1;
      rst2_n = 1'b1;
      resync();
      prev_last = 1'b0;
      clk_step();
      s_valid2 = 1'b0;
      frame("tdm0", 1'b0, 64'h0, FT, 1'b0, 1'b1);
      frame("tdm1", 1'b0, 64'h0, 64'h0, 1'b1, 1'b1);

      chkn("ws_sd_change_off_tick", glitch_cnt, 0);
      chkn("pulse_longer_than_one_clk", pulse_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_tx.md
# tdm_tx

Parametrised multi-channel serial audio transmitter, the successor to the fixed stereo I2S transmitter. It generates SCK and WS from the system clock and serialises NUM_CH channels per frame (stereo I2S when NUM_CH=2, TDM otherwise). Samples arrive through a valid/ready handshake into a one-frame holding buffer, which decouples the upstream audio pipeline from frame timing. Underflow is detected and flagged.

## Interface
- DAT_WDTH, 24: sample width in bits. Must satisfy 1 ≤ DAT_WDTH ≤ SLOT_WDTH.
- SLOT_WDTH, 32: SCK cycles per channel slot.
- NUM_CH, 2: channels per frame. Must be even and ≥ 2.
- CLK_DIV, 4: clk cycles per SCK half-period (≥ 1). The SCK period is 2·CLK_DIV clk cycles.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  NUM_CH·DAT_WDTH  one frame of samples; channel c occupies bits [c·DAT_WDTH +: DAT_WDTH].
- s_valid  in  1  s_data is valid.
- s_ready  out  1  holding buffer is empty.
- sck  out  1  serial bit clock.
- ws  out  1  frame/word select.
- sd  out  1  serial data, MSB first.
- frame_start  out  1  one-clk pulse marking bit 0 of each frame.
- underflow  out  1  one-clk pulse when a frame starts with no data held.

## Operation
- **Reset values:** sck=0, ws=0, sd=0, frame_start=0, underflow=0, s_ready=1. The holding buffer is emptied and the active frame is zeroed.
- **Divider:** a down-counter resets to CLK_DIV-1. At 0 it reloads CLK_DIV-1 and toggles sck; otherwise it decrements.
- **Tick:** a tick is a clk edge where the counter is 0 and sck is 1, so sck falls on that edge. ws, sd, frame_start and underflow update only on ticks.
- **Bit position counter:**
  - Range 0..FRAME-1, where FRAME = NUM_CH·SLOT_WDTH.
  - Resets to FRAME-1 and increments with wrap on each tick. The first tick after reset is therefore position 0.
- **Slot and bit mapping:**
  - Slot s = pos / SLOT_WDTH carries channel s; b = pos mod SLOT_WDTH.
  - For b < DAT_WDTH, the output bit is sample[DAT_WDTH-1-b]. For b ≥ DAT_WDTH, it is 0 (LSB-end padding).
- **ws:** 0 for positions 0..FRAME/2-1 and 1 for the rest. With NUM_CH=2, ch0 is left (ws=0) and ch1 is right (ws=1).
- **Handshake:**
  - s_ready = !hold_full. A transfer occurs on any clk edge with s_valid && s_ready; s_data is captured into hold and hold_full is set.
  - s_data is ignored when no transfer occurs.
- **Frame start (tick entering position 0):**
  - If hold_full: active ← hold and hold_full clears, so s_ready returns to 1 on the next clk.
  - Otherwise: active ← 0 and underflow pulses.
  - frame_start pulses in both cases.
  - A frame accepted on the same edge as a frame-start tick is not used for that frame (ready was 1, hold was empty). It is held for the next frame, and underflow still pulses for the current one.
- **Reset mid-operation:** all state returns to reset values immediately. Held and active samples are discarded.

## Timing
- Each sck phase lasts CLK_DIV clk cycles. The first sck rise occurs at the CLK_DIV-th clk edge after rst_n deasserts, and the first tick at the 2·CLK_DIV-th.
- ws and sd change only on sck falling edges and are stable across each rising edge.
- frame_start and underflow are high for exactly the one clk cycle following the tick edge.
- Latency from acceptance to first sd bit: up to one frame plus one tick.
- Sustained throughput: one accepted frame per FRAME ticks. Holding s_valid high produces exactly one transfer per frame, with no underflow after the first frame.

## Configuration
- TDM_TX_I2S_DELAY_EN defined: sd lags ws by one SCK cycle, per the Philips I2S standard.
  - At position p, sd carries the bit mapped to p-1. At position 0, it carries the last bit of the previous frame (0 after reset).
- Undefined: left-justified; sd carries the bit mapped to p. ws timing is identical in both modes.

## Test plan
- **Stereo serialisation:** defaults; push L=0xABCDEF, R=0x123456 before the first tick.
  - sck period is 8 clk; ws is 0 for 32 SCK then 1 for 32 SCK.
  - sd = 0xABCDEF MSB first followed by 8 zeros, then 0x123456 followed by 8 zeros.
- **Starvation:** s_valid=0 for 3 frames → underflow and frame_start pulse every 64 ticks; sd stays 0; s_ready stays 1.
- **Back-to-back:** s_valid held high with an incrementing pattern for 5 frames.
  - s_ready drops for the rest of each frame after a transfer.
  - No underflow after frame 0; every value appears once, in order.
- **TDM:** NUM_CH=4, SLOT_WDTH=16, DAT_WDTH=16, channels 0x1111/0x2222/0x3333/0x4444 → ws is 0 for 32 SCK then 1 for 32 SCK; slots appear in channel order.
- **Reset mid-frame:** drop rst_n in slot 1 with hold full → sck/ws/sd/pulses go to 0 and s_ready to 1 immediately; after release, the first frame underflows.
- **Macro check:** repeat the stereo test with TDM_TX_I2S_DELAY_EN defined → identical ws; sd is delayed by exactly one SCK; first sd bit at position 0 is 0.
